// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA raster pipeline.
// Defaults describe 800x600@60 with a 40 MHz pixel clock.
package vga_pkg;

    localparam int unsigned COUNT_W     = 11;
    localparam int unsigned RGB_W       = 12;
    localparam int unsigned FRAME_CNT_W = 16;

    localparam int unsigned VGA_H_ACTIVE = 800;
    localparam int unsigned VGA_H_FP     = 40;
    localparam int unsigned VGA_H_SYNC   = 128;
    localparam int unsigned VGA_H_BP     = 88;
    localparam int unsigned VGA_V_ACTIVE = 600;
    localparam int unsigned VGA_V_FP     = 1;
    localparam int unsigned VGA_V_SYNC   = 4;
    localparam int unsigned VGA_V_BP     = 23;
    localparam logic        VGA_SYNC_POL = 1'b1;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned HCOUNT_MAX  = VGA_H_TOTAL - 1;
    localparam int unsigned VCOUNT_MAX  = VGA_V_TOTAL - 1;

    typedef logic [COUNT_W-1:0] vga_count_t;

endpackage

// File: rtl/vga_if.sv
// Raster timing bundle passed between video pipeline stages.
interface vga_if;
    import vga_pkg::*;

    vga_count_t       hcount;
    vga_count_t       vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with blanking and sync decode.
// Every output is registered from the next count, so all stay aligned with cnt.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL      = VGA_H_TOTAL,
    parameter int unsigned ACTIVE     = VGA_H_ACTIVE,
    parameter int unsigned SYNC_START = VGA_H_ACTIVE + VGA_H_FP,
    parameter int unsigned SYNC_W     = VGA_H_SYNC,
    parameter logic        SYNC_POL   = VGA_SYNC_POL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output vga_count_t cnt,
    output logic       wrap,
    output logic       blnk,
    output logic       sync
);

    localparam int unsigned SYNC_END = SYNC_START + SYNC_W;
    localparam vga_count_t  CNT_MAX  = COUNT_W'(TOTAL - 1);

    vga_count_t cnt_q, cnt_d;
    logic       wrap_q, wrap_d;
    logic       blnk_q, blnk_d;
    logic       sync_q, sync_d;

    // wrap flags "cnt is at its last value", so the next enabled step returns to 0
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap_q ? '0 : cnt_q + COUNT_W'(1);
        end
        wrap_d = (cnt_d == CNT_MAX);
        blnk_d = (32'(cnt_d) >= ACTIVE);
        sync_d = ((32'(cnt_d) >= SYNC_START) && (32'(cnt_d) < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= (TOTAL == 1);
            blnk_q <= 1'b0;
            sync_q <= ~SYNC_POL;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            blnk_q <= blnk_d;
            sync_q <= sync_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign blnk = blnk_q;
    assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator with line/frame strobes and a
// wrapping frame counter for game logic.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        SYNC_POL = VGA_SYNC_POL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_en,
    vga_if.master                  out,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2 ** COUNT_W) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL does not fit the count width");
    end
    if (V_TOTAL > 2 ** COUNT_W) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL does not fit the count width");
    end

    logic h_wrap;
    logic v_wrap;
    logic v_en;

    // Vertical axis steps on the same edge that returns hcount to 0
    assign v_en = pix_en & h_wrap;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_W     (H_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_h_axis (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .cnt  (out.hcount),
        .wrap (h_wrap),
        .blnk (out.hblnk),
        .sync (out.hsync)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_W     (V_SYNC),
        .SYNC_POL   (SYNC_POL)
    ) u_v_axis (
        .clk  (clk),
        .rst  (rst),
        .en   (v_en),
        .cnt  (out.vcount),
        .wrap (v_wrap),
        .blnk (out.vblnk),
        .sync (out.vsync)
    );

    assign out.rgb = '0;

    logic                   line_start_q, line_start_d;
    logic                   frame_start_q, frame_start_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Strobes mark the cycle in which the counts land on 0; cleared on idle cycles
    always_comb begin
        line_start_d  = pix_en & h_wrap;
        frame_start_d = pix_en & h_wrap & v_wrap;
        frame_cnt_d   = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing table, a reduced-timing instance under
// random stimulus against an arithmetic raster model, and a 1x1 raster for counter wrap.
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int unsigned ha, hfp, hs, hbp, va, vfp, vs, vbp;
        bit          pol;
    } cfg_t;

    typedef struct {
        int unsigned t;
        obs_t        exp;
    } vec_t;

    localparam int unsigned B_HA = 16, B_HFP = 2, B_HS = 4, B_HBP = 3;
    localparam int unsigned B_VA = 8,  B_VFP = 1, B_VS = 2, B_VBP = 2;
    localparam int unsigned B_FRAME = (B_HA + B_HFP + B_HS + B_HBP) * (B_VA + B_VFP + B_VS + B_VBP);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, pix_en_a = 1'b1;
    logic rst_b = 1'b1, pix_en_b = 1'b1;
    logic rst_c = 1'b1, pix_en_c = 1'b1;
    logic ls_a, fs_a, ls_b, fs_b, ls_c, fs_c;
    logic [15:0] fc_a, fc_b, fc_c;

    vga_if if_a ();
    vga_if if_b ();
    vga_if if_c ();

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .pix_en(pix_en_a), .out(if_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP), .SYNC_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_en(pix_en_b), .out(if_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
        .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0), .SYNC_POL(1'b1)
    ) dut_c (
        .clk(clk), .rst(rst_c), .pix_en(pix_en_c), .out(if_c),
        .line_start(ls_c), .frame_start(fs_c), .frame_cnt(fc_c)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned t_a, t_b, t_c;
    cfg_t cfg_b, cfg_c;
    vec_t vec_a[$];

    function automatic obs_t obs_of(input int unsigned h, v, input bit hs, vs, hb, vb,
                                    input logic [11:0] rgb, input bit ls, fs, input int unsigned fc);
        obs_t o;
        o.h = 11'(h); o.v = 11'(v);
        o.hs = hs; o.vs = vs; o.hb = hb; o.vb = vb;
        o.rgb = rgb; o.ls = ls; o.fs = fs; o.fc = 16'(fc);
        return o;
    endfunction

    function automatic vec_t mk(input int unsigned t, h, v, input bit hs, vs, hb, vb, ls, fs);
        vec_t r;
        r.t   = t;
        r.exp = obs_of(h, v, hs, vs, hb, vb, 12'h000, ls, fs, 0);
        return r;
    endfunction

    // Raster position follows from the number of enabled ticks since reset
    function automatic obs_t model(input cfg_t c, input int unsigned t, input bit stepped);
        int unsigned ht, vt, h, line, v, hs0, vs0;
        obs_t o;
        ht   = c.ha + c.hfp + c.hs + c.hbp;
        vt   = c.va + c.vfp + c.vs + c.vbp;
        h    = t % ht;
        line = t / ht;
        v    = line % vt;
        hs0  = c.ha + c.hfp;
        vs0  = c.va + c.vfp;
        o.h  = 11'(h);
        o.v  = 11'(v);
        o.hb = (h >= c.ha);
        o.vb = (v >= c.va);
        o.hs = (h >= hs0 && h < hs0 + c.hs) ? c.pol : ~c.pol;
        o.vs = (v >= vs0 && v < vs0 + c.vs) ? c.pol : ~c.pol;
        o.rgb = 12'h000;
        o.ls = stepped && (h == 0);
        o.fs = o.ls && (v == 0);
        o.fc = 16'(line / vt);
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h ls=%b fs=%b fc=%h",
                         o.h, o.v, o.hs, o.vs, o.hb, o.vb, o.rgb, o.ls, o.fs, o.fc);
    endfunction

    function automatic obs_t obs_a();
        return obs_of(if_a.hcount, if_a.vcount, if_a.hsync, if_a.vsync, if_a.hblnk, if_a.vblnk,
                      if_a.rgb, ls_a, fs_a, fc_a);
    endfunction
    function automatic obs_t obs_b();
        return obs_of(if_b.hcount, if_b.vcount, if_b.hsync, if_b.vsync, if_b.hblnk, if_b.vblnk,
                      if_b.rgb, ls_b, fs_b, fc_b);
    endfunction
    function automatic obs_t obs_c();
        return obs_of(if_c.hcount, if_c.vcount, if_c.hsync, if_c.vsync, if_c.hblnk, if_c.vblnk,
                      if_c.rgb, ls_c, fs_c, fc_c);
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %s ; want %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input bit r, input bit en, input string tag);
        rst_b    = r;
        pix_en_b = en;
        tick();
        if (r) t_b = 0;
        else if (en) t_b++;
        check($sformatf("%s_t%0d", tag, t_b), obs_b(), model(cfg_b, t_b, !r && en));
    endtask

    initial begin
        int unsigned bad;
        cfg_b = '{B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, 1'b0};
        cfg_c = '{1, 0, 0, 0, 1, 0, 0, 0, 1'b1};

        //            t     h     v  hs vs hb vb ls fs
        vec_a.push_back(mk(0,    0,    0, 0, 0, 0, 0, 0, 0));
        vec_a.push_back(mk(1,    1,    0, 0, 0, 0, 0, 0, 0));
        vec_a.push_back(mk(5,    5,    0, 0, 0, 0, 0, 0, 0));
        vec_a.push_back(mk(9,    9,    0, 0, 0, 0, 0, 0, 0));
        vec_a.push_back(mk(799,  799,  0, 0, 0, 0, 0, 0, 0));
        vec_a.push_back(mk(800,  800,  0, 0, 0, 1, 0, 0, 0));
        vec_a.push_back(mk(839,  839,  0, 0, 0, 1, 0, 0, 0));
        vec_a.push_back(mk(840,  840,  0, 1, 0, 1, 0, 0, 0));
        vec_a.push_back(mk(967,  967,  0, 1, 0, 1, 0, 0, 0));
        vec_a.push_back(mk(968,  968,  0, 0, 0, 1, 0, 0, 0));
        vec_a.push_back(mk(1055, 1055, 0, 0, 0, 1, 0, 0, 0));
        vec_a.push_back(mk(1056, 0,    1, 0, 0, 0, 0, 1, 0));
        vec_a.push_back(mk(1057, 1,    1, 0, 0, 0, 0, 0, 0));
        vec_a.push_back(mk(2112, 0,    2, 0, 0, 0, 0, 1, 0));

        // Default 800x600 timing, first two lines
        tick();
        rst_a = 1'b0;
        t_a   = 0;
        foreach (vec_a[i]) begin
            while (t_a < vec_a[i].t) begin
                tick();
                t_a++;
            end
            check($sformatf("a_vec%0d_t%0d", i, vec_a[i].t), obs_a(), vec_a[i].exp);
        end

        // Reduced timing: one full frame at pix_en=1
        step_b(1'b1, 1'b1, "b_reset");
        for (int i = 0; i < int'(B_FRAME); i++) step_b(1'b0, 1'b1, "b_frame");
        check("b_frame_end", obs_b(), obs_of(0, 0, 1, 1, 0, 0, 12'h000, 1, 1, 1));

        // pix_en alternating: frame takes twice as many clocks, no strobes on idle cycles
        step_b(1'b1, 1'b1, "b_reset2");
        bad = 0;
        for (int i = 0; i < 2 * int'(B_FRAME); i++) begin
            step_b(1'b0, (i % 2) == 0, "b_half");
            if (!pix_en_b && (ls_b || fs_b)) bad++;
        end
        check_int("b_idle_strobes", int'(bad), 0);
        check_int("b_half_frame_cnt", int'(fc_b), 1);
        check_int("b_half_vcount", int'(if_b.vcount), 0);

        // Reset mid-frame with pix_en high, after one frame already counted
        step_b(1'b1, 1'b1, "b_reset3");
        for (int i = 0; i < int'(B_FRAME) + 5 * 25 + 10; i++) step_b(1'b0, 1'b1, "b_pre");
        check_int("b_pre_hcount", int'(if_b.hcount), 10);
        check_int("b_pre_vcount", int'(if_b.vcount), 5);
        step_b(1'b1, 1'b1, "b_midrst");
        check("b_midrst_vals", obs_b(), obs_of(0, 0, 1, 1, 0, 0, 12'h000, 0, 0, 0));
        for (int i = 0; i < 30; i++) step_b(1'b0, 1'b1, "b_post");

        // Random enables and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step_b($urandom_range(0, 799) == 0, $urandom_range(0, 3) != 0, "b_rand");
        end

        // 1x1 raster: every enabled tick completes a frame, exercising the 16-bit wrap
        rst_c = 1'b0;
        t_c   = 0;
        check("c_reset", obs_c(), model(cfg_c, 0, 1'b0));
        for (int i = 1; i <= 65537; i++) begin
            tick();
            t_c++;
            if (i <= 2 || i >= 65535) begin
                check($sformatf("c_t%0d", t_c), obs_c(), model(cfg_c, t_c, 1'b1));
            end
            if (i == 65535) check_int("c_cnt_max", int'(fc_c), 32'h0000_FFFF);
            if (i == 65536) begin
                check_int("c_cnt_wrap", int'(fc_c), 0);
                check_int("c_wrap_frame_start", int'(fs_c), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running VGA raster timing generator; first stage of the video pipeline.
- Produces hcount/vcount, sync and blanking on a vga_if, and drives rgb to 12'h000.
- Drawing stages and the frame-buffer stage consume these signals downstream.
- Also provides frame/line strobes and a frame counter for game logic (animation, buffer swap bookkeeping).

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1'b1, asserted level of hsync/vsync; 800x600@60 is positive

Ports:
- clk  input  1  pixel-domain clock
- rst  input  1  synchronous, active-high reset
- pix_en  input  1  pixel clock enable; counters advance only when 1; tie high for 1 pixel/clk
- out  output  vga_if.out  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
- line_start  output  1  one-cycle pulse when hcount becomes 0
- frame_start  output  1  one-cycle pulse when hcount and vcount both become 0
- frame_cnt  output  16  frames completed since reset; wraps

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628). HCOUNT_MAX = H_TOTAL-1; VCOUNT_MAX = V_TOTAL-1.
- Reset values: hcount=0, vcount=0, hsync=vsync=~SYNC_POL, hblnk=vblnk=0, rgb=12'h000, line_start=0, frame_start=0, frame_cnt=0. rst overrides pix_en; a reset mid-frame restarts at (0,0) on the next edge.
- Counter update (only on cycles with pix_en=1):
  - hcount==HCOUNT_MAX: hcount<=0; otherwise hcount+1.
  - On hcount wrap: vcount==VCOUNT_MAX ? 0 : vcount+1.
  - On hcount wrap with vcount==VCOUNT_MAX: frame_cnt+1, wrapping 16'hFFFF -> 0.
- With pix_en=0, every output holds its value, except line_start and frame_start, which are forced to 0.
- All outputs are registered and computed from the next-count values, so each output is coherent with the hcount/vcount on the same cycle. Latency 0 relative to the counts.
- hblnk = (hcount >= H_ACTIVE).
- vblnk = (vcount >= V_ACTIVE).
- hsync = SYNC_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (840..967); otherwise ~SYNC_POL.
- vsync = SYNC_POL when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (601..604); otherwise ~SYNC_POL. vsync changes together with the hcount wrap.
- line_start = 1 for exactly one pix_en cycle, the cycle in which hcount is 0.
- frame_start = 1 for exactly one pix_en cycle, the cycle in which hcount=0 and vcount=0. It also coincides with line_start.
- Neither strobe fires on the first cycle after reset. The first frame_start occurs after a full frame.
- rgb is constant 12'h000; downstream stages overwrite it.
- Width rule: count fields are 11 bits. Elaboration asserts H_TOTAL <= 2048 and V_TOTAL <= 2048.

Decomposition:
- Add to vga_pkg:
  - timing constants for 800x600@60
  - HCOUNT_MAX and VCOUNT_MAX
  - COUNT_W=11, RGB_W=12
  - typedef vga_count_t = logic [COUNT_W-1:0]
- Module parameters default from the package constants.
- Natural sub-module: vga_axis_counter, instanced twice (horizontal and vertical).
  - Parameters: TOTAL, ACTIVE, SYNC_START, SYNC_W, SYNC_POL.
  - Inputs: clk, rst, en.
  - Outputs: cnt, wrap, blnk, sync.
  - The vertical instance is enabled by pix_en & h.wrap.

Test Plan:
- Reset, then 10 cycles with pix_en=1 -> hcount 0..9, vcount=0, hsync=vsync=0, hblnk=vblnk=0, rgb=12'h000, no strobes.
- Run one line -> hblnk rises at hcount=800. hsync high for hcount 840..967 (128 cycles). hcount 1055 -> 0 with vcount 0 -> 1 and line_start=1 for one cycle.
- Run a full frame -> vblnk high for vcount 600..627. vsync high for vcount 601..604 (4*1056 cycles). After 663168 cycles: frame_start=1, frame_cnt=1, counts (0,0).
- pix_en toggled 1,0,1,0 -> counts advance every other cycle. Strobes are never high on pix_en=0 cycles. Frame length becomes 2*663168 clocks.
- Assert rst at hcount=500, vcount=300 -> next edge all outputs at reset values. frame_cnt=0. Timing restarts from (0,0).
- Force frame_cnt to 16'hFFFF, complete a frame -> frame_cnt=16'h0000, frame_start=1.
